// File: rtl/fill_seq_pkg.sv
// Shared types and constants for the RAM fill sequencer.
// No logic: state encoding, channel count and counter width helper.
// No flow control.
package fill_seq_pkg;

  localparam int NUM_CH = 2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_IDLE = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  // Width of a down-counter that must hold the value `timeout`.
  function automatic int tcnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Single-bit multi-flop synchronizer for an asynchronous level signal.
// Latency: STAGES clk cycles. No flow control.
// Ports: clk, rst_n (async active-low), d (async input), q (synchronized output).
// STAGES must be at least 2; RESET_VAL is the level presented while in reset.
module bit_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/fill_sequencer.sv
// Sequences the two per-bank RAM fill engines and reports busy/done/error/elapsed.
// Latency: fill_start one cycle after accept; done >= 2 cycles after accept.
// Backpressure: none; start is a request pulse honoured only while idle, otherwise dropped.
// Ports: sys_clk/sys_resetn; start, ch_enable, sequential (request);
//        fill_start, fill_idle (engine handshake); busy, done, error, elapsed (status).
module fill_sequencer
  import fill_seq_pkg::*;
#(
  parameter int START_TIMEOUT = 256,
  parameter int SYNC_STAGES   = 2
) (
  input  logic              sys_clk,
  input  logic              sys_resetn,
  input  logic              start,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic              sequential,
  output logic [NUM_CH-1:0] fill_start,
  input  logic [NUM_CH-1:0] fill_idle,
  output logic              busy,
  output logic              done,
  output logic [NUM_CH-1:0] error,
  output logic [63:0]       elapsed
);

  localparam int TW = tcnt_width(START_TIMEOUT);

  state_t            state;
  logic [NUM_CH-1:0] en;       // channels requested for this run
  logic              seq;
  logic [NUM_CH-1:0] fin;      // channels already launched or rejected this run
  logic [NUM_CH-1:0] act;      // channels launched in the current launch step
  logic [TW-1:0]     tcnt;
  logic [NUM_CH-1:0] idle_s;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_sync
    // Reset to idle so a reset never looks like a busy engine.
    bit_sync #(
      .STAGES   (SYNC_STAGES),
      .RESET_VAL(1'b1)
    ) u_sync (
      .clk  (sys_clk),
      .rst_n(sys_resetn),
      .d    (fill_idle[i]),
      .q    (idle_s[i])
    );
  end

  logic [NUM_CH-1:0] rem, lowest, sel, go, pre_busy, stuck;

  always_comb begin
    rem      = en & ~fin;
    lowest   = rem & (~rem + {{(NUM_CH-1){1'b0}}, 1'b1});  // isolate lowest set bit
    sel      = seq ? lowest : rem;
    go       = sel & idle_s;
    pre_busy = sel & ~idle_s;   // engine already running before we asked it to
    stuck    = act & idle_s;    // launched but never left idle
  end

  assign fill_start = (state == S_LAUNCH) ? go : '0;
  assign busy       = (state == S_LAUNCH) || (state == S_WAIT_BUSY) || (state == S_WAIT_IDLE);
  assign done       = (state == S_DONE);

  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state   <= S_IDLE;
      en      <= '0;
      seq     <= 1'b0;
      fin     <= '0;
      act     <= '0;
      tcnt    <= '0;
      error   <= '0;
      elapsed <= '0;
    end else begin
      // Counts every non-idle cycle, which includes the done cycle.
      if (state != S_IDLE) elapsed <= elapsed + 64'd1;

      case (state)
        S_IDLE: begin
          if (start) begin
            en      <= ch_enable;
            seq     <= sequential;
            fin     <= '0;
            act     <= '0;
            error   <= '0;
            elapsed <= '0;
            state   <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          fin   <= fin | sel;
          error <= error | pre_busy;
          act   <= go;
          if (go != '0) begin
            tcnt  <= TW'(START_TIMEOUT);
            state <= S_WAIT_BUSY;
          end else if ((rem & ~sel) == '0) begin
            state <= S_DONE;
          end
          // else: a sequential pick was rejected; re-evaluate next channel.
        end
        S_WAIT_BUSY: begin
          if (tcnt != '0) tcnt <= tcnt - TW'(1);
          if ((act & idle_s) == '0) begin
            state <= S_WAIT_IDLE;
          end else if (tcnt <= TW'(1)) begin
            // Counter reaches zero on this edge: give up on the stuck channels.
            error <= error | stuck;
            act   <= act & ~stuck;
            if ((act & ~stuck) != '0) state <= S_WAIT_IDLE;
            else if (rem != '0)       state <= S_LAUNCH;
            else                      state <= S_DONE;
          end
        end
        S_WAIT_IDLE: begin
          if ((act & ~idle_s) == '0) state <= (rem != '0) ? S_LAUNCH : S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fill_sequencer.sv
module tb_fill_sequencer;
  import fill_seq_pkg::*;

  logic        sys_clk = 1'b0;
  logic        sys_resetn;
  logic        start;
  logic [1:0]  ch_enable;
  logic        sequential;
  logic [1:0]  fill_start;
  logic [1:0]  fill_idle;
  logic        busy, done;
  logic [1:0]  error;
  logic [63:0] elapsed;

  fill_sequencer #(.START_TIMEOUT(16), .SYNC_STAGES(2)) dut (
    .sys_clk   (sys_clk),
    .sys_resetn(sys_resetn),
    .start     (start),
    .ch_enable (ch_enable),
    .sequential(sequential),
    .fill_start(fill_start),
    .fill_idle (fill_idle),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .elapsed   (elapsed)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Engine models: leave idle 6 cycles after a pulse, return 100 cycles later.
  logic [1:0] eng_idle = 2'b11;
  logic [1:0] eng_act = 2'b00;
  logic [1:0] stuck = 2'b00;
  logic [1:0] force_low = 2'b00;
  int eng_t[2];
  int rise_cyc[2];
  assign fill_idle = eng_idle & ~force_low;

  // Cumulative observation counters; tests take differences.
  int tot_p[2];
  int last_p[2];
  int tot_done = 0;
  int last_done = 0;
  int meas = 0;

  always @(negedge sys_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!eng_act[i] && fill_start[i] && !stuck[i]) begin
        eng_act[i] = 1'b1;
        eng_t[i] = 0;
      end else if (eng_act[i]) begin
        eng_t[i] = eng_t[i] + 1;
        if (eng_t[i] == 6) eng_idle[i] = 1'b0;
        if (eng_t[i] == 106) begin
          eng_idle[i] = 1'b1;
          eng_act[i] = 1'b0;
          rise_cyc[i] = cyc;
        end
      end
      if (fill_start[i]) begin
        tot_p[i] = tot_p[i] + 1;
        last_p[i] = cyc;
      end
    end
    if (done) begin
      tot_done = tot_done + 1;
      last_done = cyc;
    end
    if (busy || done) meas = meas + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  int m0, acc_cyc;

  task automatic do_start(input logic [1:0] en, input logic sq);
    start = 1'b1;
    ch_enable = en;
    sequential = sq;
    m0 = meas;
    tick();
    start = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    logic seen;
    d0 = tot_done;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      tick();
      if (tot_done != d0) seen = 1'b1;
    end
    chk(tag, {63'd0, seen}, 64'd1);
  endtask

  int p0, p1, dn;

  initial begin
    tot_p[0] = 0; tot_p[1] = 0; last_p[0] = 0; last_p[1] = 0;
    eng_t[0] = 0; eng_t[1] = 0; rise_cyc[0] = 0; rise_cyc[1] = 0;
    sys_resetn = 1'b0;
    start = 1'b0;
    ch_enable = 2'b00;
    sequential = 1'b0;
    tick(); tick(); tick();
    sys_resetn = 1'b1;
    tick();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_fill_start", {62'd0, fill_start}, 64'd0);
    chk("rst_error", {62'd0, error}, 64'd0);
    chk("rst_elapsed", elapsed, 64'd0);

    // Empty enable: accept, launch, done; final elapsed is 2.
    do_start(2'b00, 1'b0);
    wait_done("t0_done_seen", 10);
    chk("t0_done_lat", 64'(last_done - acc_cyc), 64'd1);
    tick();
    chk("t0_elapsed", elapsed, 64'd2);
    chk("t0_error", {62'd0, error}, 64'd0);

    // 1: parallel, both channels.
    p0 = tot_p[0]; p1 = tot_p[1]; dn = tot_done;
    do_start(2'b11, 1'b0);
    repeat (50) tick();
    chk("t1_busy_mid", {63'd0, busy}, 64'd1);
    wait_done("t1_done_seen", 400);
    chk("t1_same_cycle", 64'(last_p[0] - last_p[1]), 64'd0);
    chk("t1_pulses0", 64'(tot_p[0] - p0), 64'd1);
    chk("t1_pulses1", 64'(tot_p[1] - p1), 64'd1);
    chk("t1_error", {62'd0, error}, 64'd0);
    tick();
    chk("t1_done_once", 64'(tot_done - dn), 64'd1);
    chk("t1_elapsed", elapsed, 64'(meas - m0));

    // 2: sequential, channel 1 launches 3 cycles after channel 0's idle rises.
    p0 = tot_p[0]; p1 = tot_p[1];
    do_start(2'b11, 1'b1);
    wait_done("t2_done_seen", 600);
    chk("t2_pulses0", 64'(tot_p[0] - p0), 64'd1);
    chk("t2_pulses1", 64'(tot_p[1] - p1), 64'd1);
    chk("t2_ch1_after_ch0", 64'(last_p[1] - rise_cyc[0]), 64'd3);
    chk("t2_done_after_ch1", {63'd0, last_done > rise_cyc[1]}, 64'd1);
    chk("t2_error", {62'd0, error}, 64'd0);
    tick();

    // 3: channel 0 never leaves idle -> start timeout.
    stuck = 2'b01;
    do_start(2'b01, 1'b0);
    wait_done("t3_done_seen", 100);
    chk("t3_error", {62'd0, error}, 64'd1);
    chk("t3_lat_16_18", {63'd0, (last_done - last_p[0] >= 16) && (last_done - last_p[0] <= 18)}, 64'd1);
    stuck = 2'b00;
    tick();
    do_start(2'b00, 1'b0);
    chk("t3_error_cleared", {62'd0, error}, 64'd0);
    wait_done("t3b_done_seen", 10);
    tick();

    // 4: channel 1 already busy before start.
    force_low = 2'b10;
    repeat (4) tick();
    p1 = tot_p[1];
    do_start(2'b10, 1'b0);
    wait_done("t4_done_seen", 10);
    chk("t4_done_lat", 64'(last_done - acc_cyc), 64'd1);
    chk("t4_no_pulse", 64'(tot_p[1] - p1), 64'd0);
    chk("t4_error", {62'd0, error}, 64'd2);
    force_low = 2'b00;
    repeat (4) tick();

    // 5: starts while busy and on the done cycle are ignored.
    p0 = tot_p[0]; p1 = tot_p[1];
    do_start(2'b01, 1'b0);
    repeat (10) tick();
    start = 1'b1; ch_enable = 2'b11;
    tick();
    start = 1'b0;
    wait_done("t5_done_seen", 300);
    start = 1'b1; ch_enable = 2'b00;
    tick();
    chk("t5_done_cycle_start_ignored", {63'd0, busy}, 64'd0);
    tick();
    start = 1'b0;
    chk("t5_next_start_accepted", {63'd0, busy}, 64'd1);
    wait_done("t5b_done_seen", 10);
    chk("t5_pulses0", 64'(tot_p[0] - p0), 64'd1);
    chk("t5_pulses1", 64'(tot_p[1] - p1), 64'd0);
    tick();

    // 6: reset while waiting for engines to return idle.
    do_start(2'b11, 1'b0);
    repeat (30) tick();
    chk("t6_elapsed_running", {63'd0, elapsed > 0}, 64'd1);
    #2;
    sys_resetn = 1'b0;
    #1;
    chk("t6_busy", {63'd0, busy}, 64'd0);
    chk("t6_done", {63'd0, done}, 64'd0);
    chk("t6_fill_start", {62'd0, fill_start}, 64'd0);
    chk("t6_error", {62'd0, error}, 64'd0);
    chk("t6_elapsed", elapsed, 64'd0);
    tick();
    sys_resetn = 1'b1;
    begin
      logic idle_back;
      idle_back = 1'b0;
      for (int n = 0; n < 300 && !idle_back; n++) begin
        tick();
        if (fill_idle == 2'b11) idle_back = 1'b1;
      end
      chk("t6_engines_finish", {63'd0, idle_back}, 64'd1);
    end
    repeat (4) tick();
    p0 = tot_p[0]; p1 = tot_p[1];
    do_start(2'b11, 1'b0);
    wait_done("t6_done_seen", 400);
    chk("t6_pulses0", 64'(tot_p[0] - p0), 64'd1);
    chk("t6_pulses1", 64'(tot_p[1] - p1), 64'd1);
    chk("t6_error_after", {62'd0, error}, 64'd0);
    tick();
    chk("t6_elapsed_after", elapsed, 64'(meas - m0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
